// File: rtl/field_line_clear.sv
// Tetris-style line clear: scans the settled field bottom-to-top, collapses full rows
// downward and reports the compacted field and the number of rows removed.
// Optional running score output is enabled by defining FIELD_CLEAR_SCORE_EN.
module field_line_clear #(
    parameter int ROWS = 20,
    parameter int COLS = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] field_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] field_out,
    output logic [4:0]           lines_cleared
`ifdef FIELD_CLEAR_SCORE_EN
    ,
    output logic [15:0]          score
`endif
);

    localparam int NBITS = ROWS * COLS;
    localparam int PTR_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NBITS-1:0]   r_buf;
    logic [PTR_W-1:0]   r_ptr;
    logic [4:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [NBITS-1:0]   r_field_out;
    logic [4:0]         r_lines;

    logic [ROWS-1:0]    w_full_vec;
    logic               w_row_full;
    logic               w_ptr_zero;
    logic [NBITS-1:0]   w_shift;

    // Row-is-full test for one row of the working buffer.
    function automatic logic row_full(input logic [COLS-1:0] row);
        return &row;
    endfunction

    // Per-row fullness flags so the scan is a simple vector select by pointer.
    always_comb begin
        w_full_vec = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_full_vec[i] = row_full(r_buf[i*COLS +: COLS]);
        end
    end

    assign w_row_full = w_full_vec[r_ptr];
    assign w_ptr_zero = (r_ptr == '0);

    // Collapse: rows 1..ptr take the row above, row 0 is cleared, rows below ptr keep.
    always_comb begin
        w_shift = r_buf;
        w_shift[COLS-1:0] = '0;
        for (int i = 1; i < ROWS; i++) begin
            if (PTR_W'(i) <= r_ptr) begin
                w_shift[i*COLS +: COLS] = r_buf[(i-1)*COLS +: COLS];
            end else begin
                w_shift[i*COLS +: COLS] = r_buf[i*COLS +: COLS];
            end
        end
    end

`ifdef FIELD_CLEAR_SCORE_EN
    logic [15:0] r_score;
    logic [9:0]  w_sq;
    logic [16:0] w_score_sum;
    logic [15:0] w_score_nxt;

    // Saturating accumulate of k*k, applied on the edge that enters DONE.
    always_comb begin
        w_sq        = {5'd0, r_cnt} * {5'd0, r_cnt};
        w_score_sum = {1'b0, r_score} + {7'd0, w_sq};
        if (w_score_sum[16]) begin
            w_score_nxt = 16'hFFFF;
        end else begin
            w_score_nxt = w_score_sum[15:0];
        end
    end

    // Score accumulator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_score <= 16'd0;
        end else if (r_state == ST_SCAN && w_state_nxt == ST_DONE) begin
            r_score <= w_score_nxt;
        end else begin
            r_score <= r_score;
        end
    end

    assign score = r_score;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_row_full) begin
                    w_state_nxt = ST_SHIFT;
                end else if (w_ptr_zero) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SHIFT: w_state_nxt = ST_SCAN;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Working buffer, pointer, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf       <= '0;
            r_ptr       <= '0;
            r_cnt       <= 5'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_field_out <= '0;
            r_lines     <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_buf <= field_in;
                        r_ptr <= PTR_W'(ROWS - 1);
                        r_cnt <= 5'd0;
                    end
                end
                ST_SCAN: begin
                    // A full row keeps ptr so the row dropped into place is re-tested.
                    if (!w_row_full) begin
                        if (!w_ptr_zero) begin
                            r_ptr <= r_ptr - PTR_W'(1);
                        end else begin
                            r_field_out <= r_buf;
                            r_lines     <= r_cnt;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_buf <= w_shift;
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign field_out     = r_field_out;
    assign lines_cleared = r_lines;

endmodule

// File: tb/tb_field_line_clear.sv
// Self-checking bench for field_line_clear: directed corner cases plus random fields
// compared against a row-compaction reference model.
module tb_field_line_clear;

    logic         clk;
    logic         reset;
    logic         start;
    logic [399:0] field_in;
    logic         busy;
    logic         done;
    logic [399:0] field_out;
    logic [4:0]   lines_cleared;
`ifdef FIELD_CLEAR_SCORE_EN
    logic [15:0]  score;
    int           score_exp;
`endif

    int checks = 0;
    int errors = 0;

    field_line_clear dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .field_in      (field_in),
        .busy          (busy),
        .done          (done),
        .field_out     (field_out),
        .lines_cleared (lines_cleared)
`ifdef FIELD_CLEAR_SCORE_EN
        ,
        .score         (score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [399:0] rnd400();
        logic [415:0] t;
        for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
        return t[399:0];
    endfunction

    // Reference: keep non-full rows in bottom-to-top order and stack them from the bottom.
    task automatic model(input logic [399:0] f, output logic [399:0] o, output int k);
        logic [19:0] keep[$];
        logic [19:0] row;
        k = 0;
        for (int r = 19; r >= 0; r--) begin
            row = f[r*20 +: 20];
            if (row == 20'hFFFFF) k++;
            else keep.push_back(row);
        end
        o = '0;
        for (int j = 0; j < keep.size(); j++) o[(19-j)*20 +: 20] = keep[j];
    endtask

    task automatic run_op(input logic [399:0] f, input string tag, input int hold, input bit toggle);
        logic [399:0] exp_f;
        int k;
        int lat;
        model(f, exp_f, k);
        @(negedge clk);
        field_in = f;
        start    = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int c = 0; c <= 200; c++) begin
            @(negedge clk);
            if (c >= hold) start = 1'b0;
            if (toggle) field_in = rnd400();
            chk({tag, ":busy"}, busy, 1);
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        chk({tag, ":latency"}, lat, 20 + 2*k);
        chk({tag, ":field_out"}, field_out, exp_f);
        chk({tag, ":lines"}, lines_cleared, k);
`ifdef FIELD_CLEAR_SCORE_EN
        score_exp = score_exp + k*k;
        if (score_exp > 65535) score_exp = 65535;
        chk({tag, ":score"}, score, score_exp);
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk({tag, ":done_low"}, done, 0);
            chk({tag, ":idle"}, busy, 0);
        end
        chk({tag, ":hold"}, field_out, exp_f);
    endtask

    initial begin
        logic [399:0] f;
        logic [19:0]  row;
`ifdef FIELD_CLEAR_SCORE_EN
        score_exp = 0;
`endif
        reset    = 1'b1;
        start    = 1'b0;
        field_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:field_out", field_out, 0);
        chk("rst:lines", lines_cleared, 0);
`ifdef FIELD_CLEAR_SCORE_EN
        chk("rst:score", score, 0);
`endif
        reset = 1'b0;

        run_op('0, "empty", 0, 1'b0);

        f = '0;
        f[19*20 +: 20] = 20'hFFFFF;
        f[18*20 +: 20] = 20'h00001;
        run_op(f, "one_line", 0, 1'b0);

        f = '0;
        f[19*20 +: 20] = 20'hFFFFF;
        f[17*20 +: 20] = 20'hFFFFF;
        f[15*20 +: 20] = 20'hFFFFF;
        f[13*20 +: 20] = 20'hFFFFF;
        f[12*20 +: 20] = 20'h80000;
        run_op(f, "four_sparse", 0, 1'b0);

        f = '0;
        f[19:0] = 20'hFFFFF;
        f[19*20 +: 20] = 20'h0F0F0;
        run_op(f, "top_full", 0, 1'b0);

        f = '1;
        run_op(f, "all_full_a", 0, 1'b0);
        run_op(f, "all_full_b", 0, 1'b0);

        f = rnd400();
        f[19*20 +: 20] = 20'hFFFFF;
        f[7*20 +: 20]  = 20'hFFFFF;
        run_op(f, "hold_toggle", 10, 1'b1);

        // Reset while the first SHIFT is in progress.
        f = '0;
        f[19*20 +: 20] = 20'hFFFFF;
        f[18*20 +: 20] = 20'h12345;
        @(negedge clk);
        field_in = f;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst:busy", busy, 0);
        chk("midrst:done", done, 0);
        chk("midrst:field_out", field_out, 0);
        chk("midrst:lines", lines_cleared, 0);
`ifdef FIELD_CLEAR_SCORE_EN
        chk("midrst:score", score, 0);
        score_exp = 0;
`endif
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            chk("midrst:no_done", done, 0);
        end
        run_op(f, "after_rst", 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            f = '0;
            for (int r = 0; r < 20; r++) begin
                if ($urandom_range(0, 2) == 0) row = 20'hFFFFF;
                else if ($urandom_range(0, 4) == 0) row = 20'h00000;
                else row = 20'($urandom);
                f[r*20 +: 20] = row;
            end
            run_op(f, "random", 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
